count_monitor: RTL and testbench
================================

# count_monitor

Passive checker that sits on the other end of the `counter` output interface and watches `enable`/`count` every cycle. It predicts each next count value and flags any deviation, including a bad reset value, skips, stalls and illegal wraps. It also counts mismatches and legal wrap-arounds. It is used both as an in-design health monitor and as a bound checker in unit benches; it never drives the counter.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `ERR_W`, 8: width of the saturating mismatch counter.
- `WRAP_W`, 8: width of the saturating wrap counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  counter enable, same signal the counter sees.
- `count`  in  WIDTH  counter output being checked.
- `clear`  in  1  synchronous clear of sticky/statistics outputs.
- `expected`  out  WIDTH  predicted value of `count` for the current cycle.
- `mismatch`  out  1  one-cycle pulse: previous sampled count differed from prediction.
- `err_sticky`  out  1  set on any mismatch, held until `clear`/`reset`.
- `err_count`  out  ERR_W  saturating mismatch total.
- `wrap_pulse`  out  1  one-cycle pulse on a legal max→0 transition.
- `wrap_count`  out  WRAP_W  saturating legal-wrap total.
- `state`  out  2  current FSM state (`state_t`).

## Operation
- Counter model: `count` resets to 0 and increments by 1 mod 2^WIDTH on each edge where `enable` was high before the edge. Otherwise it holds.
- Internal registers: `count_q` and `en_q`, which hold `count`/`enable` sampled at the previous edge.
- `expected` = (`count_q` + `en_q`) mod 2^WIDTH. The carry is discarded. It is forced to 0 in ST_INIT.
- FSM states:
  - ST_INIT (after reset): on the first edge with `reset` low, compare `count` against 0. Go to ST_FAULT on a mismatch, otherwise go to ST_TRACK.
  - ST_TRACK: on each edge, compare `count` against `expected`. Go to ST_FAULT on a mismatch, otherwise stay.
  - ST_FAULT: keep checking in the same way. Go to ST_TRACK after one matching edge, otherwise stay.
- Every mismatch edge pulses `mismatch`, sets `err_sticky` and increments `err_count`.
- Resync: `count_q`/`en_q` always load the observed `count`/`enable`, never the prediction. A single glitch therefore produces exactly one mismatch, not a cascade.
- Wrap: `count_q` = 2^WIDTH−1, `en_q` = 1 and `count` = 0 (a match) pulses `wrap_pulse` and increments `wrap_count`.
  - An unexpected jump to 0 is a mismatch, not a wrap.
- Saturation: `err_count` and `wrap_count` stop at all-ones.
- `clear` and an event on the same edge: clear applies first, then the event. The counter ends at 1 and `err_sticky` ends at 1.
- `clear` does not change `state`, `count_q` or `en_q`.

## Timing
- Reset values:
  - `state` = ST_INIT.
  - `expected`, `mismatch`, `err_sticky`, `err_count`, `wrap_pulse`, `wrap_count`, `count_q`, `en_q` all 0.
- Latency: a bad `count` sampled at edge k shows `mismatch`/`err_count` updated after edge k. Both are registered, so they are visible in cycle k+1.
- `mismatch` and `wrap_pulse` are high for exactly one cycle per event and are never both high.
- Asserting `reset` mid-stream clears everything immediately. The monitor returns to ST_INIT and re-checks for a count of 0.
- No handshakes. Checking is continuous every cycle outside reset.

## Structure
- Package `count_monitor_pkg`:
  - `typedef enum logic [1:0] state_t` with values ST_INIT=0, ST_TRACK=1, ST_FAULT=2. Value 3 is unused and decodes to ST_INIT.
- Sub-module `sat_counter #(W)`:
  - Ports: `clk`, `reset`, `clear`, `inc`, `value`.
  - Clear-then-increment ordering and all-ones saturation.
  - Instantiated twice, once for errors and once for wraps.

## Test plan
- Clean run: reset 2 cycles, then `enable`=1 for 40 cycles with a correct 4-bit counter → `mismatch` never high, `state`=ST_TRACK, `wrap_count`=2, `wrap_pulse` after each 15→0.
- Bad reset value: `count`=3 on the first edge after reset → `mismatch` one cycle, `err_count`=1, `state` ST_FAULT, then ST_TRACK after the next matching edge.
- Stall and skip: with `enable`=1, force `count` 5→5 and later 7→9 → `err_count`=2, each mismatch pulse exactly one cycle, no cascaded errors.
- Hold check: `enable`=0 with a constant count of 6 for 10 cycles → no errors. Force 6→7 with `enable` low → one mismatch.
- Illegal wrap and saturation: force 9→0 → mismatch, `wrap_count` unchanged. With ERR_W=2, inject 5 errors → `err_count`=3.
- Clear and mid-run reset: `clear` on a mismatch edge → `err_count`=1, `err_sticky`=1. Assert `reset` mid-count → all outputs 0 and `state` ST_INIT on the same cycle.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared types and default sizing for the count_monitor checker.
// The state encoding is visible on the monitor's state port.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ERR_W  = 8;
    localparam int DEF_WRAP_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear.
// When clear and inc arrive on the same edge, the clear is applied first and the increment second, so the counter ends at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] base;
    logic [W-1:0] next_value;

    always_comb begin
        base       = clear ? '0 : value;
        next_value = base;
        if (inc && (base != '1)) begin
            next_value = base + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Passive checker for a free-running up-counter. It predicts each count from the previous sample and flags any deviation.
// It also counts mismatches and legal wraps.
//   state    | meaning
//   ST_INIT  | after reset; the first sample must be 0
//   ST_TRACK | the last sample matched the prediction
//   ST_FAULT | the last sample mismatched; one matching sample returns to ST_TRACK
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  count,
    input  logic              clear,
    output logic [WIDTH-1:0]  expected,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [1:0]        state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic             en_q;
    logic             mm;
    logic             wrap_ev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Encoding 3 is unreachable; it behaves like ST_INIT.
    always_comb begin
        state_d  = state_q;
        expected = '0;
        case (state_q)
            ST_TRACK, ST_FAULT: expected = count_q + WIDTH'(en_q);
            default:            expected = '0;
        endcase
        mm      = (count != expected);
        wrap_ev = !mm && en_q && (count_q == '1) && (count == '0);
        case (state_q)
            ST_TRACK: state_d = mm ? ST_FAULT : ST_TRACK;
            ST_FAULT: state_d = mm ? ST_FAULT : ST_TRACK;
            default:  state_d = mm ? ST_FAULT : ST_TRACK;
        endcase
    end

    // The history registers always resync to what was observed, so one glitch gives one mismatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            en_q       <= 1'b0;
            mismatch   <= 1'b0;
            wrap_pulse <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            count_q    <= count;
            en_q       <= enable;
            mismatch   <= mm;
            wrap_pulse <= wrap_ev;
            if (mm) begin
                err_sticky <= 1'b1;
            end else if (clear) begin
                err_sticky <= 1'b0;
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (mm),
        .value (err_count)
    );

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (wrap_ev),
        .value (wrap_count)
    );

    assign state = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor. A behavioural model pushes the predicted outputs for each edge to a scoreboard.
// A second instance with a 2-bit error counter exercises saturation.
module tb_count_monitor;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] count;
    logic       clear;

    logic [3:0] expected,   expected2;
    logic       mismatch,   mismatch2;
    logic       err_sticky, err_sticky2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic       wrap_pulse, wrap_pulse2;
    logic [7:0] wrap_count, wrap_count2;
    logic [1:0] state,      state2;

    count_monitor #(.WIDTH(4), .ERR_W(8), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .count(count), .clear(clear),
        .expected(expected), .mismatch(mismatch), .err_sticky(err_sticky),
        .err_count(err_count), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
        .state(state)
    );

    count_monitor #(.WIDTH(4), .ERR_W(2), .WRAP_W(8)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .count(count), .clear(clear),
        .expected(expected2), .mismatch(mismatch2), .err_sticky(err_sticky2),
        .err_count(err_count2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2),
        .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mm;
        logic       sticky;
        logic [7:0] errs;
        logic [1:0] errs2;
        logic       wp;
        logic [7:0] wraps;
        logic [1:0] st;
        logic [3:0] expd;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mm_hi    = 0;

    // reference model state
    logic [1:0] m_st;
    logic [3:0] m_cq;
    logic       m_eq;
    logic       m_sticky;
    logic [7:0] m_err;
    logic [1:0] m_err2;
    logic [7:0] m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 2'd0; m_cq = 4'd0; m_eq = 1'b0; m_sticky = 1'b0;
        m_err = 8'd0; m_err2 = 2'd0; m_wrap = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_state",      {30'd0, state},      0);
        chk("rst_expected",   {28'd0, expected},   0);
        chk("rst_mismatch",   {31'd0, mismatch},   0);
        chk("rst_sticky",     {31'd0, err_sticky}, 0);
        chk("rst_err_count",  {24'd0, err_count},  0);
        chk("rst_wrap_pulse", {31'd0, wrap_pulse}, 0);
        chk("rst_wrap_count", {24'd0, wrap_count}, 0);
        chk("rst_err_count2", {30'd0, err_count2}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input logic en, input logic [3:0] cnt, input logic clr);
        exp_t       e;
        exp_t       got;
        logic [3:0] pred;
        logic       m;
        logic       w;
        enable = en;
        count  = cnt;
        clear  = clr;
        pred = (m_st == 2'd0) ? 4'd0 : m_cq + {3'd0, m_eq};
        m    = (cnt != pred);
        w    = !m && m_eq && (m_cq == 4'hF) && (cnt == 4'd0);
        if (clr) begin
            m_sticky = 1'b0; m_err = 8'd0; m_err2 = 2'd0; m_wrap = 8'd0;
        end
        if (m) begin
            m_sticky = 1'b1;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            if (m_err2 != 2'd3) m_err2 = m_err2 + 2'd1;
        end
        if (w && m_wrap != 8'hFF) m_wrap = m_wrap + 8'd1;
        m_st = m ? 2'd2 : 2'd1;
        m_cq = cnt;
        m_eq = en;
        e.mm = m; e.sticky = m_sticky; e.errs = m_err; e.errs2 = m_err2;
        e.wp = w; e.wraps = m_wrap; e.st = m_st; e.expd = m_cq + {3'd0, m_eq};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("mismatch",   {31'd0, mismatch},   {31'd0, got.mm});
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, got.sticky});
        chk("err_count",  {24'd0, err_count},  {24'd0, got.errs});
        chk("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, got.wp});
        chk("wrap_count", {24'd0, wrap_count}, {24'd0, got.wraps});
        chk("state",      {30'd0, state},      {30'd0, got.st});
        chk("expected",   {28'd0, expected},   {28'd0, got.expd});
        chk("err_count2", {30'd0, err_count2}, {30'd0, got.errs2});
        chk("mismatch2",  {31'd0, mismatch2},  {31'd0, got.mm});
        if (mismatch === 1'b1) mm_hi++;
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; count = 4'd0; clear = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // clean run: two legal wraps
        mm_hi = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 4'(i % 16), 1'b0);
        chk("clean_no_mismatch", mm_hi, 0);
        chk("clean_wraps", {24'd0, wrap_count}, 2);
        chk("clean_state", {30'd0, state}, 1);

        // bad reset value
        do_reset();
        step(1'b1, 4'd3, 1'b0);
        chk("badrst_err", {24'd0, err_count}, 1);
        chk("badrst_state", {30'd0, state}, 2);
        step(1'b1, 4'd4, 1'b0);
        chk("badrst_recover", {30'd0, state}, 1);

        // stall and skip
        step(1'b1, 4'd5, 1'b1);
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd10, 1'b0);
        chk("stall_skip_err", {24'd0, err_count}, 2);

        // hold with enable low, then a move while disabled
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 4'd6, 1'b0);
        chk("hold_no_err", {24'd0, err_count}, 0);
        step(1'b0, 4'd7, 1'b0);
        chk("hold_move_err", {24'd0, err_count}, 1);

        // illegal jump to zero is not a wrap
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        chk("illegal_wrap_count", {24'd0, wrap_count}, 0);
        step(1'b1, 4'd1, 1'b0);

        // saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) step(1'b1, 4'd5, 1'b0);
        chk("sat_err2", {30'd0, err_count2}, 3);
        chk("sat_err8", {24'd0, err_count}, 7);

        // clear on a mismatch edge
        step(1'b1, 4'd5, 1'b1);
        chk("clear_mm_err", {24'd0, err_count}, 1);
        chk("clear_mm_sticky", {31'd0, err_sticky}, 1);

        // clear on a wrap edge
        for (int i = 6; i < 16; i++) step(1'b1, 4'(i), 1'b0);
        step(1'b1, 4'd0, 1'b1);
        chk("clear_wrap_count", {24'd0, wrap_count}, 1);

        // mid-run reset clears immediately and re-checks for zero
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        do_reset();
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
